iobus_arbiter: RTL

- Two-master arbiter for the memory-mapped IOBUS.
- Lets the OTTER MCU (master 0) and a secondary master such as a debug/DMA engine (master 1) share the one peripheral bus: switches, LEDs, seven-segment display and clock counter.
- Sits between the masters and the top-level IOBUS decode.
- Serialises accesses into single-cycle bus beats and returns read data and an acknowledge to the granted master.

---
 rtl/iobus_arb_pkg.sv | 16 +
 rtl/iobus_arbiter_rr_pick2.sv | 22 ++
 rtl/iobus_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/iobus_arb_pkg.sv
// Shared types for the two-master IOBUS arbiter: FSM state, master index,
// and the address driven onto the bus while it is idle.
package iobus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } arb_state_t;

   typedef logic midx_t;

   // Address 0 decodes to no peripheral, so it is safe to park the bus there.
   localparam logic [31:0] IOBUS_IDLE_ADDR = 32'h0;

endpackage

// File: rtl/iobus_arbiter_rr_pick2.sv
// Combinational two-way picker: lone requester wins; on contention either
// the master not granted last (round-robin) or master 0 (fixed priority).
module rr_pick2
   import iobus_arb_pkg::*;
(
   input  logic [1:0] req,
   input  midx_t      last,
   input  logic       fixed_prio,
   output logic       gnt_valid,
   output midx_t      gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      if (req == 2'b11) begin
         gnt_idx = fixed_prio ? 1'b0 : ~last;
      end else begin
         gnt_idx = req[1];
      end
   end

endmodule

// File: rtl/iobus_arbiter.sv
// Two-master IOBUS arbiter: IDLE -> BUS (one beat) -> DONE (ACK pulse).
// Define IOBUS_ARB_STATS_EN to build the per-master completion counters.
module iobus_arbiter
   import iobus_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
)
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              M0_REQ,
   input  logic [ADDR_W-1:0] M0_ADDR,
   input  logic [DATA_W-1:0] M0_WDATA,
   input  logic              M0_WR,
   output logic [DATA_W-1:0] M0_RDATA,
   output logic              M0_ACK,
   input  logic              M1_REQ,
   input  logic [ADDR_W-1:0] M1_ADDR,
   input  logic [DATA_W-1:0] M1_WDATA,
   input  logic              M1_WR,
   output logic [DATA_W-1:0] M1_RDATA,
   output logic              M1_ACK,
   output logic [ADDR_W-1:0] IOBUS_ADDR,
   output logic [DATA_W-1:0] IOBUS_OUT,
   output logic              IOBUS_WR,
   input  logic [DATA_W-1:0] IOBUS_IN,
   output logic [31:0]       GRANT_CNT0,
   output logic [31:0]       GRANT_CNT1
);

   arb_state_t        r_state;
   midx_t             r_last;
   midx_t             r_owner;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_out;
   logic              r_wr;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;
   logic              r_ack0;
   logic              r_ack1;

   logic              w_fixed_prio;
   logic              w_gnt_valid;
   midx_t             w_gnt_idx;

   assign w_fixed_prio = (FIXED_PRIO != 0);

   rr_pick2 u_pick (
      .req        ({M1_REQ, M0_REQ}),
      .last       (r_last),
      .fixed_prio (w_fixed_prio),
      .gnt_valid  (w_gnt_valid),
      .gnt_idx    (w_gnt_idx)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= IDLE;
         r_last   <= 1'b1;
         r_owner  <= 1'b0;
         r_addr   <= ADDR_W'(IOBUS_IDLE_ADDR);
         r_out    <= '0;
         r_wr     <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_valid) begin
                  r_owner <= w_gnt_idx;
                  r_last  <= w_gnt_idx;
                  r_addr  <= w_gnt_idx ? M1_ADDR  : M0_ADDR;
                  r_out   <= w_gnt_idx ? M1_WDATA : M0_WDATA;
                  r_wr    <= w_gnt_idx ? M1_WR    : M0_WR;
                  r_state <= BUS;
               end
            end
            BUS: begin
               // Read data is captured on writes too; the master ignores it.
               if (r_owner) begin
                  r_rdata1 <= IOBUS_IN;
                  r_ack1   <= 1'b1;
               end else begin
                  r_rdata0 <= IOBUS_IN;
                  r_ack0   <= 1'b1;
               end
               r_addr  <= ADDR_W'(IOBUS_IDLE_ADDR);
               r_out   <= '0;
               r_wr    <= 1'b0;
               r_state <= DONE;
            end
            DONE: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign IOBUS_ADDR = r_addr;
   assign IOBUS_OUT  = r_out;
   // Gating with reset keeps a peripheral from committing a write mid-reset.
   assign IOBUS_WR   = r_wr & ~RST;
   assign M0_RDATA   = r_rdata0;
   assign M1_RDATA   = r_rdata1;
   assign M0_ACK     = r_ack0;
   assign M1_ACK     = r_ack1;

`ifdef IOBUS_ARB_STATS_EN
   logic [31:0] r_grant_cnt0;
   logic [31:0] r_grant_cnt1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_grant_cnt0 <= '0;
         r_grant_cnt1 <= '0;
      end else begin
         if (r_ack0) r_grant_cnt0 <= r_grant_cnt0 + 32'd1;
         if (r_ack1) r_grant_cnt1 <= r_grant_cnt1 + 32'd1;
      end
   end

   assign GRANT_CNT0 = r_grant_cnt0;
   assign GRANT_CNT1 = r_grant_cnt1;
`else
   assign GRANT_CNT0 = 32'd0;
   assign GRANT_CNT1 = 32'd0;
`endif

endmodule
